// File: rtl/axi4_dual_master_arb.sv
// 2:1 AXI4 arbiter: two core-side masters share one downstream port.
// AR/AW are round-robin arbitrated; W follows AW order; R/B steered by ID MSB.
`timescale 1ns/1ps
module axi4_dual_master_arb #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 3,
  parameter int WR_FIFO_DEPTH      = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic                            i_m0_arvalid,
  output logic                            o_m0_arready,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   i_m0_araddr,
  input  logic [AXI4_ID_WIDTH-1:0]        i_m0_arid,
  input  logic [7:0]                      i_m0_arlen,
  input  logic [2:0]                      i_m0_arsize,
  input  logic [1:0]                      i_m0_arburst,
  input  logic                            i_m0_awvalid,
  output logic                            o_m0_awready,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   i_m0_awaddr,
  input  logic [AXI4_ID_WIDTH-1:0]        i_m0_awid,
  input  logic [7:0]                      i_m0_awlen,
  input  logic [2:0]                      i_m0_awsize,
  input  logic [1:0]                      i_m0_awburst,
  input  logic                            i_m0_wvalid,
  output logic                            o_m0_wready,
  input  logic [AXI4_DATA_WIDTH-1:0]      i_m0_wdata,
  input  logic [AXI4_DATA_WIDTH/8-1:0]    i_m0_wstrb,
  input  logic                            i_m0_wlast,
  output logic                            o_m0_rvalid,
  input  logic                            i_m0_rready,
  output logic [AXI4_ID_WIDTH-1:0]        o_m0_rid,
  output logic [AXI4_DATA_WIDTH-1:0]      o_m0_rdata,
  output logic [1:0]                      o_m0_rresp,
  output logic                            o_m0_rlast,
  output logic                            o_m0_bvalid,
  input  logic                            i_m0_bready,
  output logic [AXI4_ID_WIDTH-1:0]        o_m0_bid,
  output logic [1:0]                      o_m0_bresp,
  input  logic                            i_m1_arvalid,
  output logic                            o_m1_arready,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   i_m1_araddr,
  input  logic [AXI4_ID_WIDTH-1:0]        i_m1_arid,
  input  logic [7:0]                      i_m1_arlen,
  input  logic [2:0]                      i_m1_arsize,
  input  logic [1:0]                      i_m1_arburst,
  input  logic                            i_m1_awvalid,
  output logic                            o_m1_awready,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   i_m1_awaddr,
  input  logic [AXI4_ID_WIDTH-1:0]        i_m1_awid,
  input  logic [7:0]                      i_m1_awlen,
  input  logic [2:0]                      i_m1_awsize,
  input  logic [1:0]                      i_m1_awburst,
  input  logic                            i_m1_wvalid,
  output logic                            o_m1_wready,
  input  logic [AXI4_DATA_WIDTH-1:0]      i_m1_wdata,
  input  logic [AXI4_DATA_WIDTH/8-1:0]    i_m1_wstrb,
  input  logic                            i_m1_wlast,
  output logic                            o_m1_rvalid,
  input  logic                            i_m1_rready,
  output logic [AXI4_ID_WIDTH-1:0]        o_m1_rid,
  output logic [AXI4_DATA_WIDTH-1:0]      o_m1_rdata,
  output logic [1:0]                      o_m1_rresp,
  output logic                            o_m1_rlast,
  output logic                            o_m1_bvalid,
  input  logic                            i_m1_bready,
  output logic [AXI4_ID_WIDTH-1:0]        o_m1_bid,
  output logic [1:0]                      o_m1_bresp,
  output logic                            o_out_arvalid,
  input  logic                            i_out_arready,
  output logic [AXI4_ADDRESS_WIDTH-1:0]   o_out_araddr,
  output logic [AXI4_ID_WIDTH:0]          o_out_arid,
  output logic [7:0]                      o_out_arlen,
  output logic [2:0]                      o_out_arsize,
  output logic [1:0]                      o_out_arburst,
  output logic                            o_out_awvalid,
  input  logic                            i_out_awready,
  output logic [AXI4_ADDRESS_WIDTH-1:0]   o_out_awaddr,
  output logic [AXI4_ID_WIDTH:0]          o_out_awid,
  output logic [7:0]                      o_out_awlen,
  output logic [2:0]                      o_out_awsize,
  output logic [1:0]                      o_out_awburst,
  output logic                            o_out_wvalid,
  input  logic                            i_out_wready,
  output logic [AXI4_DATA_WIDTH-1:0]      o_out_wdata,
  output logic [AXI4_DATA_WIDTH/8-1:0]    o_out_wstrb,
  output logic                            o_out_wlast,
  input  logic                            i_out_rvalid,
  output logic                            o_out_rready,
  input  logic [AXI4_ID_WIDTH:0]          i_out_rid,
  input  logic [AXI4_DATA_WIDTH-1:0]      i_out_rdata,
  input  logic [1:0]                      i_out_rresp,
  input  logic                            i_out_rlast,
  input  logic                            i_out_bvalid,
  output logic                            o_out_bready,
  input  logic [AXI4_ID_WIDTH:0]          i_out_bid,
  input  logic [1:0]                      i_out_bresp
);
  localparam int FW = AXI4_ADDRESS_WIDTH + 13;
  localparam int PW = $clog2(WR_FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t r_ar_state, w_ar_state_nxt, r_aw_state, w_aw_state_nxt;
  logic   r_ar_prio, r_aw_prio;  // master favoured on a tie (0 = m0)
  logic   w_ar_sel, w_ar_grant, w_aw_sel, w_aw_grant;
  logic [AXI4_ID_WIDTH:0] r_ar_id, r_aw_id;
  logic [FW-1:0]          r_ar_fields, r_aw_fields;
  logic [WR_FIFO_DEPTH-1:0] r_wf_src;
  logic [PW:0]            r_wf_wp, r_wf_rp;
  logic w_wf_full, w_wf_empty, w_wf_head, w_w_act, w_wf_pop, w_r_sel, w_b_sel;

  assign w_wf_empty = (r_wf_wp == r_wf_rp);
  assign w_wf_full  = (r_wf_wp[PW] != r_wf_rp[PW]) && (r_wf_wp[PW-1:0] == r_wf_rp[PW-1:0]);
  assign w_wf_head  = r_wf_src[r_wf_rp[PW-1:0]];

  always_comb begin
    w_ar_sel       = (i_m0_arvalid && i_m1_arvalid) ? r_ar_prio : i_m1_arvalid;
    w_aw_sel       = (i_m0_awvalid && i_m1_awvalid) ? r_aw_prio : i_m1_awvalid;
    w_ar_grant     = rst_n && (r_ar_state == S_IDLE) && (i_m0_arvalid || i_m1_arvalid);
    w_aw_grant     = rst_n && (r_aw_state == S_IDLE) && (i_m0_awvalid || i_m1_awvalid) && !w_wf_full;
    w_ar_state_nxt = r_ar_state;
    w_aw_state_nxt = r_aw_state;
    case (r_ar_state)
      S_IDLE:  if (w_ar_grant)    w_ar_state_nxt = S_ISSUE;
      S_ISSUE: if (i_out_arready) w_ar_state_nxt = S_IDLE;
      default: w_ar_state_nxt = S_IDLE;
    endcase
    case (r_aw_state)
      S_IDLE:  if (w_aw_grant)    w_aw_state_nxt = S_ISSUE;
      S_ISSUE: if (i_out_awready) w_aw_state_nxt = S_IDLE;
      default: w_aw_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_ar_state <= S_IDLE;
      r_aw_state <= S_IDLE;
      r_ar_prio  <= 1'b0;
      r_aw_prio  <= 1'b0;
      r_wf_wp    <= '0;
      r_wf_rp    <= '0;
    end else begin
      r_ar_state <= w_ar_state_nxt;
      r_aw_state <= w_aw_state_nxt;
      if (w_ar_grant) r_ar_prio <= ~w_ar_sel;
      if (w_aw_grant) r_aw_prio <= ~w_aw_sel;
      if (w_aw_grant) r_wf_wp <= r_wf_wp + (PW+1)'(1);
      if (w_wf_pop)   r_wf_rp <= r_wf_rp + (PW+1)'(1);
    end
  end

  // Captured request fields carry no reset: grants are already masked by rst_n.
  always_ff @(posedge clk_i) begin
    if (w_ar_grant) begin
      r_ar_id     <= {w_ar_sel, w_ar_sel ? i_m1_arid : i_m0_arid};
      r_ar_fields <= w_ar_sel ? {i_m1_araddr, i_m1_arlen, i_m1_arsize, i_m1_arburst}
                              : {i_m0_araddr, i_m0_arlen, i_m0_arsize, i_m0_arburst};
    end
    if (w_aw_grant) begin
      r_aw_id     <= {w_aw_sel, w_aw_sel ? i_m1_awid : i_m0_awid};
      r_aw_fields <= w_aw_sel ? {i_m1_awaddr, i_m1_awlen, i_m1_awsize, i_m1_awburst}
                              : {i_m0_awaddr, i_m0_awlen, i_m0_awsize, i_m0_awburst};
      r_wf_src[r_wf_wp[PW-1:0]] <= w_aw_sel;
    end
  end

  assign o_m0_arready  = w_ar_grant && !w_ar_sel;
  assign o_m1_arready  = w_ar_grant &&  w_ar_sel;
  assign o_m0_awready  = w_aw_grant && !w_aw_sel;
  assign o_m1_awready  = w_aw_grant &&  w_aw_sel;
  assign o_out_arvalid = (r_ar_state == S_ISSUE);
  assign o_out_awvalid = (r_aw_state == S_ISSUE);
  assign o_out_arid    = r_ar_id;
  assign o_out_awid    = r_aw_id;
  assign {o_out_araddr, o_out_arlen, o_out_arsize, o_out_arburst} = r_ar_fields;
  assign {o_out_awaddr, o_out_awlen, o_out_awsize, o_out_awburst} = r_aw_fields;

  // W beats only flow for a master whose AW has already been accepted upstream.
  assign w_w_act      = rst_n && !w_wf_empty;
  assign o_out_wvalid = w_w_act && (w_wf_head ? i_m1_wvalid : i_m0_wvalid);
  assign o_out_wdata  = w_wf_head ? i_m1_wdata : i_m0_wdata;
  assign o_out_wstrb  = w_wf_head ? i_m1_wstrb : i_m0_wstrb;
  assign o_out_wlast  = w_wf_head ? i_m1_wlast : i_m0_wlast;
  assign o_m0_wready  = w_w_act && !w_wf_head && i_out_wready;
  assign o_m1_wready  = w_w_act &&  w_wf_head && i_out_wready;
  assign w_wf_pop     = o_out_wvalid && i_out_wready && o_out_wlast;

  assign w_r_sel      = i_out_rid[AXI4_ID_WIDTH];
  assign w_b_sel      = i_out_bid[AXI4_ID_WIDTH];
  assign o_m0_rvalid  = rst_n && i_out_rvalid && !w_r_sel;
  assign o_m1_rvalid  = rst_n && i_out_rvalid &&  w_r_sel;
  assign o_out_rready = rst_n && (w_r_sel ? i_m1_rready : i_m0_rready);
  assign o_m0_rid     = i_out_rid[AXI4_ID_WIDTH-1:0];
  assign o_m1_rid     = i_out_rid[AXI4_ID_WIDTH-1:0];
  assign o_m0_rdata   = i_out_rdata;
  assign o_m1_rdata   = i_out_rdata;
  assign o_m0_rresp   = i_out_rresp;
  assign o_m1_rresp   = i_out_rresp;
  assign o_m0_rlast   = i_out_rlast;
  assign o_m1_rlast   = i_out_rlast;
  assign o_m0_bvalid  = rst_n && i_out_bvalid && !w_b_sel;
  assign o_m1_bvalid  = rst_n && i_out_bvalid &&  w_b_sel;
  assign o_out_bready = rst_n && (w_b_sel ? i_m1_bready : i_m0_bready);
  assign o_m0_bid     = i_out_bid[AXI4_ID_WIDTH-1:0];
  assign o_m1_bid     = i_out_bid[AXI4_ID_WIDTH-1:0];
  assign o_m0_bresp   = i_out_bresp;
  assign o_m1_bresp   = i_out_bresp;
endmodule

// File: doc/axi4_dual_master_arb.md
Name: axi4_dual_master_arb

Overview:
- 2:1 AXI4 arbiter that shares one downstream AXI4 master port between two core-side AXI4 masters (core0 = m0, core1 = m1).
- Sits between a dual-A23 core pair and the system fabric. It is the non-coherent alternative to the L1 interconnect.
- Arbitrates the AR and AW channels independently, using round-robin.
- Orders W beats through a write-order FIFO.
- Steers R/B responses back to the issuing master using an ID prefix bit.

Parameters:
- AXI4_ADDRESS_WIDTH, 32: address width on all ports.
- AXI4_DATA_WIDTH, 32: data width on all ports.
- AXI4_ID_WIDTH, 3: ID width on m0/m1. The out port ID width is AXI4_ID_WIDTH+1.
- WR_FIFO_DEPTH, 4: write-order FIFO entries. Must be a power of 2, ≥2.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- m0  axi4_if.slave  (parameterised)  core0 request port; ID width AXI4_ID_WIDTH.
- m1  axi4_if.slave  (parameterised)  core1 request port; ID width AXI4_ID_WIDTH.
- out  axi4_if.master  (parameterised)  shared downstream port; ID width AXI4_ID_WIDTH+1.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out.ARVALID, out.AWVALID, out.WVALID = 0.
  - m*.RVALID, m*.BVALID = 0.
  - m*.ARREADY, m*.AWREADY, m*.WREADY = 0.
  - out.RREADY, out.BREADY = 0.
  - Both round-robin pointers favour m0.
  - Write-order FIFO empty; both address FSMs in IDLE.
  - Reset mid-transaction discards all state; downstream is reset in the same domain.
- AR FSM (IDLE, ISSUE):
  - IDLE: if any m*.ARVALID, register the winner, its AR fields and out.ARID = {src, m*.ARID}. Pulse the winner's ARREADY for that cycle; the upstream handshake completes. Go to ISSUE.
  - ISSUE: out.ARVALID = 1, fields held stable. On out.ARREADY, return to IDLE.
  - Round-robin: if both request, grant the master not granted last. A single requester always wins. The pointer updates on the upstream handshake.
  - Throughput: max one AR per 2 cycles; latency from m*.ARVALID to out.ARVALID is 1 cycle.
- AW FSM (IDLE, ISSUE): same as AR, with one addition.
  - In IDLE, no grant (AWREADY stays 0) while the write-order FIFO is full. A pop in the same cycle is ignored for this decision.
  - On the upstream AW handshake, push src into the FIFO.
- W path:
  - FIFO empty: out.WVALID = 0, both WREADY = 0.
  - Otherwise head = src. out.W* = m[src].W*, m[src].WREADY = out.WREADY; the other master's WREADY = 0.
  - Pop on out.WVALID && out.WREADY && WLAST.
  - W beats may precede out.AWVALID but never precede the upstream AW handshake.
- R path (combinational steering):
  - m[RID MSB].RVALID = out.RVALID, and its RID = RID[AXI4_ID_WIDTH-1:0].
  - out.RREADY = m[RID MSB].RREADY; the other master's RVALID = 0.
  - RDATA, RRESP and RLAST are passed unchanged.
- B path: same steering as R, using BID MSB.
- Simultaneous events:
  - AR and AW grants are independent and may occur in the same cycle.
  - FIFO push and pop in the same cycle when not full: count unchanged.
- No burst splitting and no response reordering. Per-master ordering is preserved by the downstream per-ID ordering rules.

Test Plan:
- Single read: m0 AR addr 0x100, ARID 2. → out.ARID 0x2 one cycle later; R beat RID 0x2 delivered to m0 with RID 2; m1.RVALID stays 0.
- Contended reads: m0 and m1 hold ARVALID continuously. → out AR grants alternate m0, m1, m0, m1 (first is m0 after reset); out.ARID MSB sequence 0, 1, 0, 1.
- Interleaved writes: m1 AW len 3 then m0 AW len 0 accepted. → out W beats are m1 ×4 (WLAST on the 4th), then m0 ×1; B with BID MSB 1 reaches m1 and MSB 0 reaches m0.
- FIFO full: 4 AWs accepted, W withheld. → 5th m0 AWVALID sees AWREADY 0 until the first WLAST handshake. It is granted in the IDLE cycle after that pop, never in the pop cycle.
- Backpressure: out.ARREADY held 0 for 10 cycles during ISSUE. → out.ARADDR/ARID stable, no further m*.ARREADY pulses; on release, FSM returns to IDLE.
- Reset mid-burst: rst_n low during W beat 2 of 4. → next cycle all VALID/READY outputs 0, FIFO empty, pointer back to m0.
